reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 131 +++++++++++++
 tb/tb_reg_dump_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
// Walks a register file from entry 0 to NUM_REGS-1 and presents each word
// on a valid/ready output stream. Each word takes two cycles: LOAD captures
// the word into the output registers, and SEND holds it until it is accepted.
//
// Ports
//   clock      sole clock, rising edge
//   clr_n      synchronous active-low reset
//   start      request one full dump (only looked at in IDLE)
//   abort      cancel the dump in progress
//   rf_addr    register-file read address (always equals the index register)
//   rf_data    register-file read data, combinational from rf_addr
//   out_valid  out_data / out_index / out_last are valid
//   out_ready  downstream accepts the word when out_valid is high
//   out_data   captured register word
//   out_index  register number of out_data
//   out_last   marks the word for register NUM_REGS-1
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last word is accepted
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              clr_n,
    input  logic              start,
    input  logic              abort,
    output logic [4:0]        rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } stateT;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    stateT      stateReg;
    logic [4:0] idxReg;

    // The read address is the index register itself, so the register file
    // sees a stable address for the whole LOAD cycle.
    assign rf_addr = idxReg;

    // All outputs are registered. done is raised on the transition into
    // DONE so that it is high exactly while the FSM sits in DONE.
    always_ff @(posedge clock) begin
        if (!clr_n) begin
            stateReg  <= IDLE;
            idxReg    <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 5'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (stateReg)
                IDLE: begin
                    // abort together with start keeps the block idle
                    if (start && !abort) begin
                        idxReg   <= 5'd0;
                        stateReg <= LOAD;
                        busy     <= 1'b1;
                    end
                end

                LOAD: begin
                    if (abort) begin
                        idxReg   <= 5'd0;
                        stateReg <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        out_data  <= rf_data;
                        out_index <= idxReg;
                        out_last  <= (idxReg == LAST_IDX);
                        out_valid <= 1'b1;
                        stateReg  <= SEND;
                    end
                end

                SEND: begin
                    // A handshake coinciding with abort still transfers the
                    // word (downstream saw valid & ready); abort then ends
                    // the dump without a done pulse.
                    if (abort) begin
                        out_valid <= 1'b0;
                        idxReg    <= 5'd0;
                        stateReg  <= IDLE;
                        busy      <= 1'b0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idxReg == LAST_IDX) begin
                            // idx stays on the last entry; no wrap
                            stateReg <= DONE;
                            done     <= 1'b1;
                        end else begin
                            idxReg   <= idxReg + 5'd1;
                            stateReg <= LOAD;
                        end
                    end
                end

                DONE: begin
                    stateReg <= IDLE;
                    busy     <= 1'b0;
                    if (abort) begin
                        idxReg <= 5'd0;
                    end
                end

                default: begin
                    stateReg <= IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

    logic clk;
    logic clr_n;

    // 32-entry instance
    logic        start, abort, out_ready;
    logic [4:0]  rf_addr, out_index;
    logic [31:0] rf_data, out_data;
    logic        out_valid, out_last, busy, done;
    logic [31:0] noise;

    // 4-entry instance
    logic        start4, abort4, ready4;
    logic [4:0]  rf_addr4, out_index4;
    logic [31:0] rf_data4, out_data4;
    logic        out_valid4, out_last4, busy4, done4;

    int total = 0;
    int bad   = 0;
    int doneCount = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  index;
        logic        last;
    } wordT;
    wordT sbQ[$];

    typedef struct {
        logic        start;
        logic        ready;
        logic        expValid;
        logic        expBusy;
        logic        expDone;
        logic [4:0]  expIndex;
        logic        expLast;
        logic [31:0] expData;
    } vecT;
    vecT vecs[11];

    // register-file models: word = 0xA0000000 + address, optionally disturbed
    assign rf_data  = (32'hA000_0000 + 32'(rf_addr)) ^ noise;
    assign rf_data4 = 32'hA000_0000 + 32'(rf_addr4);

    reg_dump_reader #(.NUM_REGS(32), .DATA_W(32)) dut (
        .clock(clk), .clr_n(clr_n), .start(start), .abort(abort),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done)
    );

    reg_dump_reader #(.NUM_REGS(4), .DATA_W(32)) dut4 (
        .clock(clk), .clr_n(clr_n), .start(start4), .abort(abort4),
        .rf_addr(rf_addr4), .rf_data(rf_data4),
        .out_valid(out_valid4), .out_ready(ready4),
        .out_data(out_data4), .out_index(out_index4), .out_last(out_last4),
        .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWords(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            wordT w;
            w.data  = 32'hA000_0000 + 32'(i);
            w.index = 5'(i);
            w.last  = (i == 31);
            sbQ.push_back(w);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        stepEdge();
        start = 1'b0;
    endtask

    task automatic waitValidIndex(input int idx);
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            stepEdge();
            if (out_valid && out_index == 5'(idx)) ok = 1;
        end
        if (!ok) chk("timeout waiting for index", 64'd0, 64'(idx));
    endtask

    task automatic waitDone(output int cycles);
        bit ok = 0;
        cycles = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            stepEdge();
            cycles++;
            if (done) ok = 1;
        end
        if (!ok) chk("timeout waiting for done", 64'd0, 64'd1);
    endtask

    // Scoreboard: one line per accepted word; pops the expected word and
    // checks data/index/last plus the read address tracking the index.
    always @(negedge clk) begin
        if (clr_n && done) doneCount++;
        if (clr_n && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                chk("unexpected word", {27'd0, out_index}, 64'hFFFF);
            end else begin
                wordT e;
                e = sbQ.pop_front();
                $display("word idx=%0d data=%h last=%0b", out_index, out_data, out_last);
                chk("scoreboard word", {out_data, out_index, out_last, rf_addr},
                    {e.data, e.index, e.last, e.index});
            end
        end
    end

    initial begin
        int cyc;
        int doneBase;

        // 4-entry dump with out_ready alternating 0/1
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 32'hA000_0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 32'hA000_0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'hA000_0000};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 32'hA000_0001};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 32'hA000_0001};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 32'hA000_0002};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 32'hA000_0002};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 32'hA000_0003};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 32'hA000_0003};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 32'hA000_0003};

        clr_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; noise = 32'd0;
        start4 = 1'b0; abort4 = 1'b0; ready4 = 1'b0;
        repeat (3) stepEdge();

        // reset state of both instances
        chk("reset outputs", {rf_addr, out_valid, out_data, out_index, out_last, busy, done}, 64'd0);
        chk("reset outputs n4", {rf_addr4, out_valid4, out_data4, out_index4, out_last4, busy4, done4}, 64'd0);
        $display("reset checked");
        clr_n = 1'b1;
        stepEdge();

        // table-driven 4-entry run
        for (int i = 0; i < 11; i++) begin
            start4 = vecs[i].start;
            ready4 = vecs[i].ready;
            stepEdge();
            $display("vec %0d valid=%0b busy=%0b done=%0b idx=%0d last=%0b data=%h",
                     i, out_valid4, busy4, done4, out_index4, out_last4, out_data4);
            chk($sformatf("vec%0d", i),
                {out_valid4, busy4, done4, out_index4, out_last4, out_data4},
                {vecs[i].expValid, vecs[i].expBusy, vecs[i].expDone,
                 vecs[i].expIndex, vecs[i].expLast, vecs[i].expData});
        end
        ready4 = 1'b0;

        // full dump with out_ready high: latency and throughput
        doneBase = doneCount;
        out_ready = 1'b1;
        pushWords(0, 31);
        start = 1'b1;
        stepEdge();
        start = 1'b0;
        chk("load cycle busy/valid", {busy, out_valid}, {1'b1, 1'b0});
        stepEdge();
        chk("first word latency", {out_valid, out_index}, {1'b1, 5'd0});
        waitDone(cyc);
        chk("done cycle", 64'(cyc + 2), 64'd65);
        stepEdge();
        chk("idle after dump", {busy, done, out_valid}, 3'b000);
        chk("dump1 queue empty", 64'(sbQ.size()), 64'd0);
        chk("dump1 one done", 64'(doneCount - doneBase), 64'd1);

        // backpressure on index 3 with rf_data changing
        doneBase = doneCount;
        pushWords(0, 31);
        pulseStart();
        waitValidIndex(3);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            noise = $urandom | 32'h1;
            stepEdge();
            chk($sformatf("hold%0d", k), {out_valid, out_index, out_data}, {1'b1, 5'd3, 32'hA000_0003});
        end
        noise = 32'd0;
        out_ready = 1'b1;
        waitDone(cyc);
        stepEdge();
        chk("dump2 queue empty", 64'(sbQ.size()), 64'd0);
        chk("dump2 one done", 64'(doneCount - doneBase), 64'd1);

        // abort together with a handshake at index 10
        doneBase = doneCount;
        pushWords(0, 10);
        pulseStart();
        waitValidIndex(10);
        abort = 1'b1;
        stepEdge();
        abort = 1'b0;
        chk("after abort", {out_valid, busy, done, rf_addr}, {1'b0, 1'b0, 1'b0, 5'd0});
        repeat (3) stepEdge();
        chk("abort queue empty", 64'(sbQ.size()), 64'd0);
        chk("abort no done", 64'(doneCount - doneBase), 64'd0);

        // start held high: one dump, second begins only after done
        doneBase = doneCount;
        pushWords(0, 31);
        start = 1'b1;
        waitDone(cyc);
        chk("held start first dump", 64'(sbQ.size()), 64'd0);
        pushWords(0, 31);
        stepEdge();
        chk("idle between dumps", {busy, out_valid}, 2'b00);
        stepEdge();
        chk("second dump starts", busy, 1'b1);
        start = 1'b0;
        waitDone(cyc);
        stepEdge();
        chk("held start queue empty", 64'(sbQ.size()), 64'd0);
        chk("held start two dones", 64'(doneCount - doneBase), 64'd2);

        // reset at index 20
        doneBase = doneCount;
        pushWords(0, 19);
        pulseStart();
        waitValidIndex(20);
        clr_n = 1'b0;
        out_ready = 1'b0;
        stepEdge();
        chk("mid-dump reset", {rf_addr, out_valid, out_data, out_index, out_last, busy, done}, 64'd0);
        clr_n = 1'b1;
        stepEdge();
        chk("reset queue empty", 64'(sbQ.size()), 64'd0);
        chk("reset no done", 64'(doneCount - doneBase), 64'd0);
        doneBase = doneCount;
        out_ready = 1'b1;
        pushWords(0, 31);
        start = 1'b1;
        stepEdge();
        start = 1'b0;
        stepEdge();
        chk("post-reset first index", {out_valid, out_index}, {1'b1, 5'd0});
        waitDone(cyc);
        stepEdge();
        chk("post-reset queue empty", 64'(sbQ.size()), 64'd0);
        chk("post-reset one done", 64'(doneCount - doneBase), 64'd1);

        // abort with start in IDLE keeps the block idle
        start = 1'b1;
        abort = 1'b1;
        stepEdge();
        chk("abort+start idle", {busy, out_valid}, 2'b00);
        stepEdge();
        chk("abort+start still idle", {busy, out_valid}, 2'b00);
        start = 1'b0;
        abort = 1'b0;
        stepEdge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
